// File: rtl/fdd_host_seek.sv
// Host-side floppy head-positioning controller: issues timed active-low step
// pulses for seek/recalibrate commands and tracks the current cylinder.
module fdd_host_seek #(
  parameter int DRIVE_NUM      = 1,
  parameter int MAX_TRACK      = 79,
  parameter int RECAL_MAX      = 85,
  parameter int DIR_SETUP_CYC  = 2,
  parameter int STEP_PULSE_CYC = 4,
  parameter int STEP_RATE_CYC  = 10,
  parameter int SETTLE_CYC     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       motor_req,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_recal,
  input  logic [6:0] cmd_track,
  output logic       done,
  output logic       error,
  output logic       trk_valid,
  output logic [6:0] cur_track,
  output logic [3:0] drive_sel_n,
  output logic       motor_on_n,
  output logic       dir_sel,
  output logic       step_n,
  input  logic       track_0_n,
  input  logic       ready_n
);
  localparam int TW = $clog2(DIR_SETUP_CYC + STEP_RATE_CYC + SETTLE_CYC + 1);
  localparam int CW = $clog2(RECAL_MAX + 1);
  localparam logic [TW-1:0] T_SETUP  = TW'(DIR_SETUP_CYC - 1);
  localparam logic [TW-1:0] T_PULSE  = TW'(STEP_PULSE_CYC - 1);
  localparam logic [TW-1:0] T_GAP    = TW'(STEP_RATE_CYC - STEP_PULSE_CYC - 1);
  localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] STEP_LIM = CW'(RECAL_MAX);
  localparam logic [6:0]    MAX_T    = 7'(MAX_TRACK);
  localparam logic [1:0]    SEL_IDX  = 2'(DRIVE_NUM);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_GAP, S_SETTLE, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] steps_q, steps_d;
  logic [6:0]    cur_q, cur_d, target_q, target_d;
  logic          recal_q, recal_d, dir_q, dir_d;
  logic          step_n_q, step_n_d, err_q, err_d, valid_q, valid_d;
  logic [3:0]    sel_n_q, sel_n_d;
  logic          motor_n_q;
  logic [1:0]    t0_sync_q, rdy_sync_q;
  logic          t0, rdy, go_pulse;

  assign t0  = ~t0_sync_q[1];
  assign rdy = ~rdy_sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      steps_q    <= '0;
      cur_q      <= '0;
      target_q   <= '0;
      recal_q    <= 1'b0;
      dir_q      <= 1'b0;
      step_n_q   <= 1'b1;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      sel_n_q    <= 4'hF;
      motor_n_q  <= 1'b1;
      t0_sync_q  <= 2'b11;
      rdy_sync_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      steps_q    <= steps_d;
      cur_q      <= cur_d;
      target_q   <= target_d;
      recal_q    <= recal_d;
      dir_q      <= dir_d;
      step_n_q   <= step_n_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      sel_n_q    <= sel_n_d;
      motor_n_q  <= ~motor_req;
      t0_sync_q  <= {t0_sync_q[0], track_0_n};
      rdy_sync_q <= {rdy_sync_q[0], ready_n};
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    steps_d  = steps_q;
    cur_d    = cur_q;
    target_d = target_q;
    recal_d  = recal_q;
    dir_d    = dir_q;
    step_n_d = step_n_q;
    err_d    = err_q;
    valid_d  = valid_q;
    go_pulse = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          recal_d  = cmd_recal;
          target_d = cmd_track;
          err_d    = 1'b0;
          if (cmd_recal) begin
            dir_d   = 1'b1;
            steps_d = '0;
            timer_d = T_SETUP;
            state_d = S_SETUP;
          end else if (!valid_q || cmd_track > MAX_T || !rdy) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (cmd_track == cur_q) begin
            state_d = S_DONE;
          end else begin
            dir_d   = (cmd_track < cur_q);
            timer_d = T_SETUP;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (timer_q == '0) go_pulse = 1'b1;
        else               timer_d  = timer_q - TW'(1);
      end
      S_PULSE: begin
        if (timer_q == '0) begin
          step_n_d = 1'b1;
          timer_d  = T_GAP;
          state_d  = S_GAP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (!recal_q && cur_q == target_q) begin
          timer_d = T_SETTLE;
          state_d = S_SETTLE;
        end else begin
          go_pulse = 1'b1;
        end
      end
      S_SETTLE: begin
        if (timer_q == '0) state_d = S_DONE;
        else               timer_d = timer_q - TW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Recalibrate decides at each would-be pulse start, so no pulse follows an observed track 0.
    if (go_pulse) begin
      if (recal_q && t0) begin
        cur_d   = '0;
        valid_d = 1'b1;
        err_d   = 1'b0;
        timer_d = T_SETTLE;
        state_d = S_SETTLE;
      end else if (recal_q && steps_q == STEP_LIM) begin
        valid_d = 1'b0;
        err_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        if (recal_q)    steps_d = steps_q + CW'(1);
        else if (dir_q) cur_d   = cur_q - 7'd1;
        else            cur_d   = cur_q + 7'd1;
        step_n_d = 1'b0;
        timer_d  = T_PULSE;
        state_d  = S_PULSE;
      end
    end

    sel_n_d = 4'hF;
    if (motor_req || state_d != S_IDLE) sel_n_d[SEL_IDX] = 1'b0;
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE);
  assign error       = err_q;
  assign trk_valid   = valid_q;
  assign cur_track   = cur_q;
  assign drive_sel_n = sel_n_q;
  assign motor_on_n  = motor_n_q;
  assign dir_sel     = dir_q;
  assign step_n      = step_n_q;
endmodule
